sum_accumulator: RTL and testbench
==================================

# sum_accumulator

- Downstream consumer of the 3-bit adder's 4-bit `sum` output.
- Accepts a stream of sums over a valid/ready handshake and accumulates blocks of N consecutive samples.
- Presents each block's total and its maximum sample on a valid/ready output port.
- Holds the result until the downstream side takes it, then starts the next block; used to checksum adder output streams in lab exercises.

## Interface
- `IN_W`, default 4: width of an incoming sum (matches the adder's 4-bit output).
- `N`, default 8: samples per block; legal range 1..256.
- `OUT_W`, derived localparam = IN_W + $clog2(N) (min IN_W when N=1): total width; the accumulator cannot overflow.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous clear; abandons the current block and drops any pending result.
- `in_valid` input 1: `in_sum` is valid.
- `in_ready` output 1: block can accept a sample this cycle.
- `in_sum` input IN_W: unsigned sum sample.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `out_total` output OUT_W: unsigned sum of the N samples of the block.
- `out_max` output IN_W: largest sample in the block.

## Operation
- **States:** ACCUM, DONE.
- **Reset** (async, `rst_n`=0) sets:
  - state ACCUM;
  - `acc`=0, `cnt`=0, `max`=0;
  - `out_valid`=0, `out_total`=0, `out_max`=0.
  - `in_ready` is 1 after reset deasserts.
- **`in_ready`** = (state==ACCUM) && !`clr`. This is a pure decode, not registered.
- **Sample accepted** (`in_valid` && `in_ready`) in ACCUM:
  - `acc` += zero-extended `in_sum`;
  - `max` = larger of `max` and `in_sum`;
  - `cnt` increments.
- **Block complete** (accept while `cnt`==N-1):
  - the final values of `acc` and `max` are loaded into `out_total` / `out_max`;
  - `out_valid` goes to 1 and the state goes to DONE;
  - `acc`, `max` and `cnt` are zeroed.
- **DONE:**
  - `in_ready`=0.
  - `out_total` and `out_max` are held stable while `out_valid` && !`out_ready`.
  - `out_valid` && `out_ready` → next cycle: `out_valid`=0, state ACCUM.
- **`clr`** has priority over every other event in the same cycle:
  - next state ACCUM;
  - `acc`, `cnt`, `max` = 0;
  - `out_valid` = 0;
  - `out_total` and `out_max` keep their old values (don't-care).
- **N=1:** every accepted sample completes a block; `out_total` = zero-extended sample and `out_max` = the sample.
- **Idle input:** `in_valid`=0 cycles in ACCUM change nothing; gaps are allowed anywhere inside a block.
- **Width:** all arithmetic is unsigned. `acc` is OUT_W bits wide; the maximum value (2^IN_W-1)·N fits by construction.

## Timing
- **Latency:** `out_valid` rises on the clock edge that accepts the Nth sample; it is visible in the following cycle.
- **Throughput:** at best N+1 cycles per block, because DONE always takes at least one cycle. No sample is accepted while a result is pending.
- **Held outputs:** `out_total` and `out_max` are registered and change only on the completion edge.
- **Reset mid-block or mid-DONE:** all registers clear immediately; no partial result is ever presented.
- **`clr` with `in_valid`=1:** the sample is not accepted (`in_ready` is forced to 0).
- **`clr` with `out_ready`=1 in DONE:** the clear wins. The transfer still counts as completed by the downstream side, and `out_valid` is 0 afterwards.

## Structure
- **Shared package `adder_pkg`:**
  - `ADDER_IN_W` = 3 and `ADDER_SUM_W` = 4, reused for IN_W;
  - typedef `acc_state_t` enum {ACCUM, DONE}.
- **Single module, no sub-modules.**
  - The datapath (adder, max comparator, counter) is too small to split out.
  - The two-state FSM lives inline.

## Test plan
- **Full-scale block:** N=8; eight samples of 15 back-to-back, `out_ready`=1 → `out_valid` one cycle after the 8th accept, `out_total`=120, `out_max`=15; `in_ready`=0 for exactly one cycle.
- **Mixed values with gaps:** samples 0,1,2,…,7 with `in_valid` low on alternate cycles → `out_total`=28, `out_max`=7.
- **Backpressure:** result pending with `out_ready`=0 for 5 cycles while `in_valid`=1 → `out_valid`, `out_total` and `out_max` stable; `in_ready`=0 throughout. No sample is lost: the next block starts with the sample presented after `out_ready` rises.
- **`clr` mid-block:** after 3 samples of 9, assert `clr` for one cycle, then feed eight samples of 2 → `out_total`=16, `out_max`=2.
- **Async reset during DONE:** drop `rst_n` between clock edges → `out_valid`=0 immediately and `out_total`=0. After release, `in_ready`=1 and the next 8 samples of 1 give `out_total`=8.
- **N=1 build:** samples 5, 12, 0 → three results: totals 5, 12, 0; max equal to each sample.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder lab blocks and their downstream consumers.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   ADDER_IN_W / ADDER_SUM_W : operand and sum widths of the 3-bit adder
//   acc_state_t              : block accumulator state (ACCUM, DONE)
//   acc_width / cnt_width    : width helpers shared by the accumulator and its interface
package adder_pkg;

    localparam int ADDER_IN_W  = 3;
    localparam int ADDER_SUM_W = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    // Total width for a block of n samples of in_w bits. n*(2^in_w-1) never
    // exceeds 2^(in_w+clog2(n))-1, so the accumulator cannot overflow.
    function automatic int acc_width(input int in_w, input int n);
        return in_w + $clog2(n);
    endfunction

    // Sample counter width; N=1 still needs a one-bit register to stay legal.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample-in / result-out handshake bundle for sum_accumulator.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; master drives samples and out_ready.
//
// Signals:
//   in_valid/in_ready/in_sum          : sample stream into the accumulator
//   out_valid/out_ready/out_total/max : block result out of the accumulator
// IN_W and N must match the parameters of the attached sum_accumulator.
interface sum_accumulator_if
    import adder_pkg::*;
#(
    parameter int IN_W = ADDER_SUM_W,
    parameter int N    = 8
);
    localparam int OUT_W = acc_width(IN_W, N);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_total;
    logic [IN_W-1:0]  out_max;

    // Producer of samples / consumer of results.
    modport master (
        output in_valid,
        output in_sum,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_total,
        input  out_max
    );

    // The accumulator itself.
    modport slave (
        input  in_valid,
        input  in_sum,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_total,
        output out_max
    );

endinterface

// File: rtl/sum_accumulator.sv
// Accumulates blocks of N adder sums and reports each block's total and maximum.
// Latency: out_valid is registered on the edge accepting the Nth sample (visible next cycle).
// Backpressure: in_ready drops while a result is pending; result held until out_ready.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear, beats every other event in the same cycle
//   bus    : sum_accumulator_if.slave (sample input + result output handshakes)
// Parameters: IN_W sample width, N samples per block (1..256).
module sum_accumulator
    import adder_pkg::*;
#(
    parameter int IN_W = ADDER_SUM_W,
    parameter int N    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    sum_accumulator_if.slave bus
);

    localparam int OUT_W = acc_width(IN_W, N);
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    acc_state_t       state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [IN_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovld_q, ovld_d;
    logic [OUT_W-1:0] total_q, total_d;
    logic [IN_W-1:0]  omax_q, omax_d;

    logic             accept;
    logic [OUT_W-1:0] acc_sum;
    logic [IN_W-1:0]  max_new;

    // Pure decode: clr blocks acceptance in the same cycle it is asserted.
    assign bus.in_ready = (state_q == ACCUM) && !clr;
    assign accept       = bus.in_valid && bus.in_ready;

    // Running totals including the sample on the bus this cycle.
    assign acc_sum = acc_q + OUT_W'(bus.in_sum);
    assign max_new = (bus.in_sum > max_q) ? bus.in_sum : max_q;

    assign bus.out_valid = ovld_q;
    assign bus.out_total = total_q;
    assign bus.out_max   = omax_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        ovld_d  = ovld_q;
        total_d = total_q;
        omax_d  = omax_q;

        if (clr) begin
            // Result registers keep stale data; out_valid low makes them meaningless.
            state_d = ACCUM;
            acc_d   = '0;
            max_d   = '0;
            cnt_d   = '0;
            ovld_d  = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (cnt_q == LAST) begin
                            // Last sample goes straight into the result so the
                            // block total is available without an extra cycle.
                            total_d = acc_sum;
                            omax_d  = max_new;
                            ovld_d  = 1'b1;
                            state_d = DONE;
                            acc_d   = '0;
                            max_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            acc_d = acc_sum;
                            max_d = max_new;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (ovld_q && bus.out_ready) begin
                        ovld_d  = 1'b0;
                        state_d = ACCUM;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            ovld_q  <= 1'b0;
            total_q <= '0;
            omax_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            ovld_q  <= ovld_d;
            total_q <= total_d;
            omax_q  <= omax_d;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: N=8 and N=1 instances against a queue-based block model.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low while samples are offered.
module tb_sum_accumulator;
    import adder_pkg::*;

    localparam int IW = ADDER_SUM_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr8  = 1'b0;
    logic clr1  = 1'b0;

    always #5 clk = ~clk;

    sum_accumulator_if #(.IN_W(IW), .N(8)) b8 ();
    sum_accumulator_if #(.IN_W(IW), .N(1)) b1 ();

    sum_accumulator #(.IN_W(IW), .N(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr8),
        .bus   (b8)
    );

    sum_accumulator #(.IN_W(IW), .N(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr1),
        .bus   (b1)
    );

    int vectors = 0;
    int errs    = 0;

    // Reference model: samples of the open block, and the pending result if any.
    int blk8[$];
    int blk1[$];
    bit pend8 = 1'b0;
    bit pend1 = 1'b0;
    int tot8, mx8, tot1, mx1;

    function automatic int qsum(input int q[$]);
        int t = 0;
        foreach (q[i]) t += q[i];
        return t;
    endfunction

    function automatic int qmax(input int q[$]);
        int m = 0;
        foreach (q[i]) if (q[i] > m) m = q[i];
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv8(input bit v, input int s, input bit r);
        b8.in_valid  = v;
        b8.in_sum    = IW'(s);
        b8.out_ready = r;
    endtask

    task automatic drv1(input bit v, input int s, input bit r);
        b1.in_valid  = v;
        b1.in_sum    = IW'(s);
        b1.out_ready = r;
    endtask

    // Apply the block rules to the inputs present at the coming edge.
    task automatic model_edge();
        if (clr8) begin
            blk8.delete();
            pend8 = 1'b0;
        end else if (pend8) begin
            if (b8.out_ready) pend8 = 1'b0;
        end else if (b8.in_valid) begin
            blk8.push_back(int'(b8.in_sum));
            if (blk8.size() == 8) begin
                tot8  = qsum(blk8);
                mx8   = qmax(blk8);
                pend8 = 1'b1;
                blk8.delete();
            end
        end

        if (clr1) begin
            blk1.delete();
            pend1 = 1'b0;
        end else if (pend1) begin
            if (b1.out_ready) pend1 = 1'b0;
        end else if (b1.in_valid) begin
            blk1.push_back(int'(b1.in_sum));
            if (blk1.size() == 1) begin
                tot1  = qsum(blk1);
                mx1   = qmax(blk1);
                pend1 = 1'b1;
                blk1.delete();
            end
        end
    endtask

    // One clock: check in_ready before the edge, outputs 1 time unit after it.
    task automatic tick();
        #1;
        chk("in_ready8", 32'(b8.in_ready), 32'(!pend8 && !clr8));
        chk("in_ready1", 32'(b1.in_ready), 32'(!pend1 && !clr1));
        model_edge();
        @(posedge clk);
        #1;
        chk("out_valid8", 32'(b8.out_valid), 32'(pend8));
        if (pend8) begin
            chk("out_total8", 32'(b8.out_total), 32'(tot8));
            chk("out_max8",   32'(b8.out_max),   32'(mx8));
        end
        chk("out_valid1", 32'(b1.out_valid), 32'(pend1));
        if (pend1) begin
            chk("out_total1", 32'(b1.out_total), 32'(tot1));
            chk("out_max1",   32'(b1.out_max),   32'(mx1));
        end
    endtask

    initial begin
        drv8(0, 0, 1);
        drv1(0, 0, 1);

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        chk("rst_out_valid8", 32'(b8.out_valid), 32'd0);
        chk("rst_out_total8", 32'(b8.out_total), 32'd0);
        chk("rst_out_max8",   32'(b8.out_max),   32'd0);
        chk("rst_out_valid1", 32'(b1.out_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready8", 32'(b8.in_ready), 32'd1);

        // Full-scale block, back-to-back
        for (int i = 0; i < 8; i++) begin
            drv8(1, 15, 1);
            tick();
        end
        chk("full_valid",    32'(b8.out_valid), 32'd1);
        chk("full_total",    32'(b8.out_total), 32'd120);
        chk("full_max",      32'(b8.out_max),   32'd15);
        chk("full_rdy_low",  32'(b8.in_ready),  32'd0);
        drv8(0, 0, 1);
        tick();
        chk("full_rdy_back", 32'(b8.in_ready),  32'd1);

        // Mixed values with alternate idle cycles
        for (int i = 0; i < 8; i++) begin
            drv8(1, i, 1);
            tick();
            if (i == 7) begin
                chk("gap_total", 32'(b8.out_total), 32'd28);
                chk("gap_max",   32'(b8.out_max),   32'd7);
            end
            drv8(0, 0, 1);
            tick();
        end

        // Backpressure: pending result while samples keep being offered
        for (int i = 0; i < 8; i++) begin
            drv8(1, int'($urandom_range(0, 15)), 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drv8(1, 11, 0);
            tick();
            chk("bp_held_valid", 32'(b8.out_valid), 32'd1);
        end
        drv8(1, 11, 1);
        tick();
        drv8(1, 11, 1);
        tick();
        for (int i = 0; i < 7; i++) begin
            drv8(1, 3, 1);
            tick();
        end
        chk("bp_next_total", 32'(b8.out_total), 32'd32);
        chk("bp_next_max",   32'(b8.out_max),   32'd11);
        drv8(0, 0, 1);
        tick();

        // clr mid-block, with a sample offered in the clear cycle
        for (int i = 0; i < 3; i++) begin
            drv8(1, 9, 1);
            tick();
        end
        clr8 = 1'b1;
        drv8(1, 9, 1);
        tick();
        clr8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drv8(1, 2, 1);
            tick();
        end
        chk("clr_total", 32'(b8.out_total), 32'd16);
        chk("clr_max",   32'(b8.out_max),   32'd2);
        drv8(0, 0, 1);
        tick();

        // clr in DONE with out_ready high: clear wins, nothing pending after
        for (int i = 0; i < 8; i++) begin
            drv8(1, int'($urandom_range(0, 15)), 0);
            tick();
        end
        clr8 = 1'b1;
        drv8(0, 0, 1);
        tick();
        clr8 = 1'b0;
        chk("clr_done_valid", 32'(b8.out_valid), 32'd0);

        // Async reset while a result is pending
        for (int i = 0; i < 8; i++) begin
            drv8(1, 4, 0);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(b8.out_valid), 32'd0);
        chk("arst_total", 32'(b8.out_total), 32'd0);
        chk("arst_max",   32'(b8.out_max),   32'd0);
        blk8.delete();
        blk1.delete();
        pend8 = 1'b0;
        pend1 = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("arst_in_ready", 32'(b8.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drv8(1, 1, 1);
            tick();
        end
        chk("arst_next_total", 32'(b8.out_total), 32'd8);
        drv8(0, 0, 1);
        tick();

        // N=1 build: every sample is a block
        begin
            int smp[3];
            smp[0] = 5;
            smp[1] = 12;
            smp[2] = 0;
            for (int i = 0; i < 3; i++) begin
                drv1(1, smp[i], 1);
                tick();
                chk("n1_valid", 32'(b1.out_valid), 32'd1);
                chk("n1_total", 32'(b1.out_total), 32'(smp[i]));
                chk("n1_max",   32'(b1.out_max),   32'(smp[i]));
                drv1(0, 0, 1);
                tick();
            end
        end

        // Random traffic on both instances
        for (int c = 0; c < 600; c++) begin
            drv8(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0));
            drv1(($urandom_range(0, 1) != 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0));
            clr8 = ($urandom_range(0, 49) == 0);
            clr1 = ($urandom_range(0, 49) == 0);
            tick();
        end
        clr8 = 1'b0;
        clr1 = 1'b0;
        drv8(0, 0, 1);
        drv1(0, 0, 1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
